hv_supply_sequencer: RTL

Power-up/power-down sequencer that drives the grid (G1) and anode supply activation requests into the card 2 interlock logic and consumes its permission/OK status. Enables G1 first, waits for G1 OK, then requests anode, waits for anode OK, and reports running. Shuts down in reverse order and latches a coded fault on timeout or on loss of permission or OK. Sits between the operator command logic and the card 2 interlock block.

---
 rtl/rpsc_pkg.sv | 64 ++++++
 rtl/hv_supply_sequencer_if.sv | 27 ++
 rtl/tick_gen.sv | 27 ++
 rtl/hv_supply_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/rpsc_pkg.sv
// Shared types and small helpers for the HV supply sequencer and its sibling card timers.
// State and fault encodings are visible on the debug outputs, so their values are fixed.
package rpsc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    G1_RAMP  = 3'd1,
    AN_WAIT  = 3'd2,
    AN_RAMP  = 3'd3,
    RUNNING  = 3'd4,
    SHUTDOWN = 3'd5,
    FAULT    = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    NONE         = 3'd0,
    G1_TMO       = 3'd1,
    AN_PERM_TMO  = 3'd2,
    AN_TMO       = 3'd3,
    G1_PERM_LOST = 3'd4,
    G1_OK_LOST   = 3'd5,
    AN_OK_LOST   = 3'd6,
    AN_PERM_LOST = 3'd7
  } fault_code_t;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // G1 stays requested through the whole sequence, including the settle phase.
  function automatic logic g1_requested(input seq_state_t s);
    return s inside {G1_RAMP, AN_WAIT, AN_RAMP, RUNNING, SHUTDOWN};
  endfunction

  // Anode is only requested in states that already require G1.
  function automatic logic an_requested(input seq_state_t s);
    return s inside {AN_RAMP, RUNNING};
  endfunction

  function automatic fault_code_t timeout_code(input seq_state_t s);
    case (s)
      G1_RAMP: return G1_TMO;
      AN_WAIT: return AN_PERM_TMO;
      AN_RAMP: return AN_TMO;
      default: return NONE;
    endcase
  endfunction

  function automatic seq_state_t ramp_successor(input seq_state_t s);
    case (s)
      G1_RAMP: return AN_WAIT;
      AN_WAIT: return AN_RAMP;
      AN_RAMP: return RUNNING;
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/hv_supply_sequencer_if.sv
// Signal bundle between operator command logic / card 2 interlock and the HV sequencer.
// All signals are levels: commands and status are sampled every clock, outputs are registered.
interface hv_supply_sequencer_if;
  logic       start_cmd;
  logic       stop_cmd;
  logic       fault_clr;
  logic       g1_perm_n;
  logic       g1_ok_n;
  logic       an_perm;
  logic       an_ok_n;
  logic       g1_ps_act;
  logic       an_ps_act;
  logic       ready;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] state;

  modport master (
    output start_cmd, stop_cmd, fault_clr, g1_perm_n, g1_ok_n, an_perm, an_ok_n,
    input  g1_ps_act, an_ps_act, ready, fault, fault_code, state
  );

  modport slave (
    input  start_cmd, stop_cmd, fault_clr, g1_perm_n, g1_ok_n, an_perm, an_ok_n,
    output g1_ps_act, an_ps_act, ready, fault, fault_code, state
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Reused by other cards' timers; it never restarts except on reset.
module tick_gen #(
  parameter int unsigned TICK_DIV = 781250
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/hv_supply_sequencer.sv
// G1/anode power-up and power-down sequencer with coded, latched faults.
// Outputs are registered from the next state so they move on the same edge as state.
module hv_supply_sequencer
  import rpsc_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 781250,
  parameter int unsigned G1_TIMEOUT      = 192,
  parameter int unsigned AN_PERM_TIMEOUT = 64,
  parameter int unsigned AN_TIMEOUT      = 320,
  parameter int unsigned SETTLE          = 64
) (
  input logic                  clk,
  input logic                  reset,
  hv_supply_sequencer_if.slave sq
);
  localparam int unsigned TMAX = max4(G1_TIMEOUT, AN_PERM_TIMEOUT, AN_TIMEOUT, SETTLE);
  localparam int TW = $clog2(TMAX) + 1;

  seq_state_t    cur_state, nxt_state;
  fault_code_t   cur_code, nxt_code;
  logic [TW-1:0] timer, timer_nxt;
  logic          tick;
  logic          tmo_hit;
  logic          advance;
  logic          g1_ok_checked, an_perm_checked;
  logic          g1_act_q, an_act_q, ready_q, fault_q;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Timeout compares against the count including this cycle's tick, so the
  // transition lands on the edge that delivers the Nth tick.
  assign timer_nxt = (tick && (timer != '1)) ? timer + TW'(1) : timer;

  always_comb begin
    tmo_hit = 1'b0;
    case (cur_state)
      G1_RAMP:  tmo_hit = (timer_nxt >= TW'(G1_TIMEOUT));
      AN_WAIT:  tmo_hit = (timer_nxt >= TW'(AN_PERM_TIMEOUT));
      AN_RAMP:  tmo_hit = (timer_nxt >= TW'(AN_TIMEOUT));
      SHUTDOWN: tmo_hit = (timer_nxt >= TW'(SETTLE));
      default:  tmo_hit = 1'b0;
    endcase
  end

  assign g1_ok_checked   = cur_state inside {AN_WAIT, AN_RAMP, RUNNING};
  assign an_perm_checked = cur_state inside {AN_RAMP, RUNNING};
  assign advance = ((cur_state == G1_RAMP) && !sq.g1_ok_n) ||
                   ((cur_state == AN_WAIT) &&  sq.an_perm) ||
                   ((cur_state == AN_RAMP) && !sq.an_ok_n);

  // Priority within the active states: permission/OK losses, then timeout,
  // then stop, then forward progress.
  always_comb begin
    nxt_state = cur_state;
    nxt_code  = (cur_state == FAULT) ? cur_code : NONE;
    case (cur_state)
      IDLE: begin
        if (sq.start_cmd && !sq.stop_cmd && !sq.g1_perm_n) nxt_state = G1_RAMP;
      end
      G1_RAMP, AN_WAIT, AN_RAMP, RUNNING: begin
        if (sq.g1_perm_n) begin
          nxt_state = FAULT;
          nxt_code  = G1_PERM_LOST;
        end else if (g1_ok_checked && sq.g1_ok_n) begin
          nxt_state = FAULT;
          nxt_code  = G1_OK_LOST;
        end else if (an_perm_checked && !sq.an_perm) begin
          nxt_state = FAULT;
          nxt_code  = AN_PERM_LOST;
        end else if ((cur_state == RUNNING) && sq.an_ok_n) begin
          nxt_state = FAULT;
          nxt_code  = AN_OK_LOST;
        end else if (tmo_hit) begin
          nxt_state = FAULT;
          nxt_code  = timeout_code(cur_state);
        end else if (sq.stop_cmd) begin
          nxt_state = SHUTDOWN;
        end else if (advance) begin
          nxt_state = ramp_successor(cur_state);
        end
      end
      SHUTDOWN: begin
        if (sq.g1_perm_n) begin
          nxt_state = FAULT;
          nxt_code  = G1_PERM_LOST;
        end else if (tmo_hit) begin
          nxt_state = IDLE;
        end
      end
      FAULT: begin
        if (sq.fault_clr && !sq.start_cmd) begin
          nxt_state = IDLE;
          nxt_code  = NONE;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_code  = NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      cur_code  <= NONE;
      timer     <= '0;
      g1_act_q  <= 1'b0;
      an_act_q  <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      cur_code  <= nxt_code;
      timer     <= (nxt_state != cur_state) ? '0 : timer_nxt;
      g1_act_q  <= g1_requested(nxt_state);
      an_act_q  <= an_requested(nxt_state);
      ready_q   <= (nxt_state == RUNNING);
      fault_q   <= (nxt_state == FAULT);
    end
  end

  assign sq.g1_ps_act  = g1_act_q;
  assign sq.an_ps_act  = an_act_q;
  assign sq.ready      = ready_q;
  assign sq.fault      = fault_q;
  assign sq.fault_code = cur_code;
  assign sq.state      = cur_state;
endmodule
